var_len_packer: RTL and testbench
=================================

# var_len_packer

Parametrised successor to the compression-path aligner. It packs a stream of variable-length compressed records (tag + payload, byte-granular length) into dense fixed-width output words. It adds valid/ready handshaking on both sides, downstream back-pressure, an explicit end-of-stream flush that emits a zero-padded partial word, and a sticky length-error flag. It sits between the compressor output FIFO and the packed-output FIFO.

## Interface
Parameters:
- IN_WIDTH, 272, input record width in bits (tag + payload); multiple of 8; IN_BYTES = IN_WIDTH/8.
- OUT_WIDTH, 256, output word width in bits; multiple of 8; OUT_BYTES = OUT_WIDTH/8.
- LEN_WIDTH, 8, width of in_len; must hold IN_BYTES.
- Derived: BUF_BYTES = IN_BYTES + OUT_BYTES; FILL_W = clog2(BUF_BYTES+1); OCNT_W = clog2(OUT_BYTES+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- in_data  in  IN_WIDTH  record; the valid bytes are the low in_len bytes, and byte 0 (bits 7:0) is first in the stream.
- in_len  in  LEN_WIDTH  valid byte count, 0..IN_BYTES.
- in_last  in  1  end of stream; flush after this beat.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_WIDTH  packed word, byte 0 first; bytes at index ≥ out_bytes are zero.
- out_bytes  out  OCNT_W  valid bytes in out_data; OUT_BYTES except on a last word.
- out_last  out  1  final word of the stream.
- len_err  out  1  sticky; set when an accepted beat has in_len > IN_BYTES.

## Operation
- State: byte buffer buf (BUF_BYTES), byte count fill, FSM {RUN, FLUSH}, output register (out_data, out_bytes, out_last, out_valid).
- Reset values: fill=0, buf=0, state=RUN, out_valid=0, out_data=0, out_bytes=0, out_last=0, len_err=0.
- in_ready = (state==RUN) && (fill <= OUT_BYTES). It depends only on registered state; there is no combinational path from out_ready or in_valid.
- slot_free = !out_valid || out_ready.
- Each cycle:
  - Emit, evaluated first, on the current fill:
    - RUN: if slot_free and fill ≥ OUT_BYTES, load bytes 0..OUT_BYTES-1 into out_data, with out_bytes=OUT_BYTES, out_last=0. Shift buf down by OUT_BYTES and set fill -= OUT_BYTES.
    - FLUSH: if slot_free and fill > OUT_BYTES, emit a full word as in RUN. If slot_free and fill ≤ OUT_BYTES, load the fill bytes zero-padded, with out_bytes=fill, out_last=1, and set fill=0, state→RUN. When fill=0 this emits a word with out_bytes=0 and out_last=1.
  - Append: on in_valid && in_ready, write the low len_eff bytes of in_data at byte offset (post-emit fill), and set fill += len_eff. len_eff = min(in_len, IN_BYTES); if in_len > IN_BYTES, set len_err=1.
  - If the accepted beat has in_last=1, state→FLUSH next cycle.
  - If no load occurs and out_ready=1, out_valid→0. out_data stays stable while out_valid && !out_ready.
- Width rule: fill never exceeds BUF_BYTES; buffer bytes above fill are don't-care internally but never reach out_data.
- in_len=0 beats are accepted and leave fill unchanged. With in_last=1 they still trigger a flush.
- Reset asserted mid-operation clears everything immediately, including any pending or partially-flushed data, with no output.

## Timing
- Beat accepted at edge N: its first bytes can appear on out_data after edge N+1 (one cycle of latency).
- A word is transferred on an edge where out_valid && out_ready. A new word may load on that same edge (zero-bubble streaming).
- Sustained throughput is one output word per cycle when out_ready=1. Input is throttled whenever fill > OUT_BYTES.
- Flush latency: the last word appears ceil(fill/OUT_BYTES) cycles after FLUSH entry, given out_ready=1, with a minimum of 1 cycle.
- in_ready is low for every FLUSH cycle.
- Asynchronous reset: outputs reach reset values without waiting for clk.

## Test plan
- Reset: with reset=0 mid-stream, out_valid=0, in_ready=1 and len_err=0 immediately. After release, the first beat is accepted on the first edge.
- Single full beat: in_len=32, bytes 0x01..0x20, in_last=0. Next cycle out_valid=1, out_data byte k = k+1, out_bytes=32, out_last=0. No further word appears.
- Merge and flush: beat A in_len=20 (0xA0+k), then beat B in_len=20 (0xB0+k) with in_last=1. Word0 = A0..A19,B0..B11 with out_last=0. Word1 = B12..B19 with out_bytes=8, bytes 8..31 zero, out_last=1.
- Back-pressure: out_ready=0 for 10 cycles under continuous in_len=34 beats. in_ready falls once fill > 32, and out_data stays stable while stalled. After out_ready=1, words arrive in exact byte order with no loss or duplication.
- Length error: a beat with in_len=40 sets len_err=1 and is packed as 34 bytes. len_err stays 1 until reset.
- Empty flush: with an empty buffer, in_len=0, in_last=1 gives one word with out_bytes=0, out_data=0, out_last=1, after which in_ready returns to 1.

Source files
------------

// File: rtl/var_len_packer.sv
// Packs variable-length byte records into dense fixed-width output words,
// with valid/ready on both sides, end-of-stream flush and a sticky length error.
module var_len_packer #(
    parameter int IN_WIDTH  = 272,
    parameter int OUT_WIDTH = 256,
    parameter int LEN_WIDTH = 8,
    localparam int IN_BYTES  = IN_WIDTH / 8,
    localparam int OUT_BYTES = OUT_WIDTH / 8,
    localparam int BUF_BYTES = IN_BYTES + OUT_BYTES,
    localparam int FILL_W    = $clog2(BUF_BYTES + 1),
    localparam int OCNT_W    = $clog2(OUT_BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [LEN_WIDTH-1:0] in_len,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [OCNT_W-1:0]    out_bytes,
    output logic                 out_last,
    output logic                 len_err
);

    localparam int BUF_W = BUF_BYTES * 8;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [BUF_W-1:0]     byte_buf_q, byte_buf_d;
    logic [FILL_W-1:0]    fill_q, fill_d;

    logic                 slot_free, accept, len_over;
    logic                 emit_full, emit_part;
    logic [LEN_WIDTH-1:0] len_eff;
    logic [BUF_W-1:0]     buf_e, buf_keep, ins;
    logic [FILL_W-1:0]    fill_e;
    logic [IN_WIDTH-1:0]  in_keep;
    logic [OUT_WIDTH-1:0] out_keep, word_d;

    assign in_ready  = (state_q == RUN) && (fill_q <= FILL_W'(OUT_BYTES));
    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign len_over  = in_len > LEN_WIDTH'(IN_BYTES);
    assign len_eff   = len_over ? LEN_WIDTH'(IN_BYTES) : in_len;

    always_comb begin
        emit_full = 1'b0;
        emit_part = 1'b0;
        if (slot_free) begin
            if (state_q == RUN)
                emit_full = fill_q >= FILL_W'(OUT_BYTES);
            else if (fill_q > FILL_W'(OUT_BYTES))
                emit_full = 1'b1;
            else
                emit_part = 1'b1;
        end
    end

    // Emit is applied first; the appended record lands at the post-emit fill.
    always_comb begin
        word_d   = '0;
        out_keep = '1;
        out_keep = ~(out_keep << (fill_q * 8));
        buf_e    = byte_buf_q;
        fill_e   = fill_q;
        if (emit_full) begin
            word_d = byte_buf_q[OUT_WIDTH-1:0];
            buf_e  = byte_buf_q >> OUT_WIDTH;
            fill_e = fill_q - FILL_W'(OUT_BYTES);
        end else if (emit_part) begin
            word_d = byte_buf_q[OUT_WIDTH-1:0] & out_keep;
            buf_e  = '0;
            fill_e = '0;
        end

        in_keep  = '1;
        in_keep  = ~(in_keep << (len_eff * 8));
        buf_keep = '1;
        buf_keep = ~(buf_keep << (fill_e * 8));
        ins      = BUF_W'(in_data & in_keep) << (fill_e * 8);

        byte_buf_d = buf_e;
        fill_d     = fill_e;
        if (accept) begin
            byte_buf_d = (buf_e & buf_keep) | ins;
            fill_d     = fill_e + FILL_W'(len_eff);
        end

        state_d = state_q;
        if (emit_part)
            state_d = RUN;
        if (accept && in_last)
            state_d = FLUSH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            byte_buf_q <= '0;
            fill_q     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bytes  <= '0;
            out_last   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_buf_q <= byte_buf_d;
            fill_q     <= fill_d;
            if (accept && len_over)
                len_err <= 1'b1;
            if (emit_full || emit_part) begin
                out_valid <= 1'b1;
                out_data  <= word_d;
                out_bytes <= emit_full ? OCNT_W'(OUT_BYTES) : OCNT_W'(fill_q);
                out_last  <= emit_part;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_var_len_packer.sv
// Self-checking bench for var_len_packer: directed scenarios plus randomized
// traffic scored against a per-stream byte-queue reference model.
module tb_var_len_packer;

    localparam int IW = 272;
    localparam int OW = 256;
    localparam int IB = IW / 8;
    localparam int OB = OW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_last;
    logic [IW-1:0] in_data;
    logic [7:0]    in_len;
    logic          out_valid, out_ready, out_last, len_err;
    logic [OW-1:0] out_data;
    logic [5:0]    out_bytes;

    always #5 clk = ~clk;

    var_len_packer #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .LEN_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_len   (in_len),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_bytes(out_bytes),
        .out_last (out_last),
        .len_err  (len_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: bytes not yet emitted, and byte counts of closed streams.
    logic [7:0]    exp_q[$];
    int            seg_q[$];
    int            open_cnt = 0;
    bit            prev_stall = 0;
    logic [OW-1:0] prev_data;
    logic [5:0]    prev_bytes;
    logic          prev_last;

    task automatic score_word();
        int n, avail;
        logic [OW-1:0] w;
        avail = (seg_q.size() > 0) ? seg_q[0] : open_cnt;
        if (!out_last) begin
            n = OB;
            check("full_avail", 256'(avail >= OB), 256'(1));
        end else if (seg_q.size() > 0) begin
            n = seg_q[0];
        end else begin
            check("last_without_stream", 256'(out_last), 256'(0));
            return;
        end
        check("word_bytes", 256'(out_bytes), 256'(n));
        w = '0;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() > 0) begin
                if (k < OB) w[k*8 +: 8] = exp_q.pop_front();
                else void'(exp_q.pop_front());
            end
        end
        check("word_data", out_data, w);
        if (out_last) void'(seg_q.pop_front());
        else if (seg_q.size() > 0) seg_q[0] -= OB;
        else open_cnt -= OB;
    endtask

    task automatic model_accept();
        int le;
        le = (int'(in_len) > IB) ? IB : int'(in_len);
        for (int k = 0; k < le; k++) exp_q.push_back(in_data[k*8 +: 8]);
        open_cnt += le;
        if (in_last) begin
            seg_q.push_back(open_cnt);
            open_cnt = 0;
        end
    endtask

    // Negedge sampling: handshakes seen here complete on the following posedge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                seg_q.delete();
                open_cnt   = 0;
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 256'(out_valid), 256'(1));
                    check("stall_data", out_data, prev_data);
                    check("stall_bytes", 256'(out_bytes), 256'(prev_bytes));
                    check("stall_last", 256'(out_last), 256'(prev_last));
                end
                if (out_valid && out_ready) score_word();
                if (in_valid && in_ready) model_accept();
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_bytes = out_bytes;
                prev_last  = out_last;
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] rnd_data();
        logic [IW-1:0] r;
        for (int k = 0; k < IB; k++) r[k*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    task automatic send_beat(input logic [IW-1:0] d, input int len, input bit last);
        int n = 0;
        in_data  = d;
        in_len   = 8'(len);
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 256'(in_ready), 256'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (!(exp_q.size() == 0 && seg_q.size() == 0 && !out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 256'(exp_q.size() + seg_q.size() + int'(out_valid)), 256'(0));
        sync();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        bit            saw_low, done, seen;
        int            n;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_last = 1'b0;
        out_ready = 1'b1;
        fork monitor(); join_none
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_len_err", 256'(len_err), 256'(0));
        check("rst_out_data", out_data, '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        sync();

        // single full beat, one cycle of latency
        d = '0;
        for (int k = 0; k < OB; k++) d[k*8 +: 8] = 8'(k + 1);
        for (int k = OB; k < IB; k++) d[k*8 +: 8] = 8'hEE;
        send_beat(d, OB, 0);
        @(negedge clk) check("single_latency", 256'(out_valid), 256'(0));
        @(negedge clk);
        check("single_valid", 256'(out_valid), 256'(1));
        check("single_bytes", 256'(out_bytes), 256'(OB));
        check("single_last", 256'(out_last), 256'(0));
        check("single_data", out_data, d[OW-1:0]);
        repeat (3) @(negedge clk);
        check("single_no_extra", 256'(out_valid), 256'(0));
        sync();

        // merge two 20-byte records, then flush
        d = '0;
        for (int k = 0; k < IB; k++) d[k*8 +: 8] = (k < 20) ? 8'(8'hA0 + k) : 8'h55;
        send_beat(d, 20, 0);
        for (int k = 0; k < IB; k++) d[k*8 +: 8] = (k < 20) ? 8'(8'hB0 + k) : 8'h66;
        send_beat(d, 20, 1);
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid && !out_last) begin
                e = '0;
                for (int k = 0; k < 20; k++) e[k*8 +: 8] = 8'(8'hA0 + k);
                for (int k = 0; k < 12; k++) e[(20+k)*8 +: 8] = 8'(8'hB0 + k);
                check("merge_w0", out_data, e);
            end
            if (out_valid && out_last) begin
                seen = 1;
                e = '0;
                for (int k = 0; k < 8; k++) e[k*8 +: 8] = 8'(8'hB0 + 12 + k);
                check("merge_last_bytes", 256'(out_bytes), 256'(8));
                check("merge_last_data", out_data, e);
            end
        end
        check("merge_last_seen", 256'(seen), 256'(1));
        sync();

        // back-pressure with continuous full-width records
        out_ready = 1'b0;
        saw_low = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(rnd_data(), IB, i == 5);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!in_ready) saw_low = 1;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("bp_in_ready_low", 256'(saw_low), 256'(1));
        drain();

        // oversize length: packed as IB bytes, sticky error
        check("lerr_clear", 256'(len_err), 256'(0));
        send_beat(rnd_data(), 40, 1);
        @(negedge clk) check("lerr_set", 256'(len_err), 256'(1));
        sync();
        send_beat(rnd_data(), 10, 1);
        drain();
        check("lerr_sticky", 256'(len_err), 256'(1));

        // empty flush
        send_beat(rnd_data(), 0, 1);
        @(negedge clk);
        check("eflush_busy_ready", 256'(in_ready), 256'(0));
        check("eflush_not_yet", 256'(out_valid), 256'(0));
        @(negedge clk);
        check("eflush_valid", 256'(out_valid), 256'(1));
        check("eflush_bytes", 256'(out_bytes), 256'(0));
        check("eflush_data", out_data, '0);
        check("eflush_last", 256'(out_last), 256'(1));
        check("eflush_ready_back", 256'(in_ready), 256'(1));
        sync();
        drain();

        // randomized traffic with random back-pressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int len;
                    bit last;
                    len  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(35, 40))
                                                        : int'($urandom_range(0, IB));
                    last = ($urandom_range(0, 7) == 0) || (i == 299);
                    send_beat(rnd_data(), len, last);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // asynchronous reset mid-stream discards pending data
        out_ready = 1'b0;
        send_beat(rnd_data(), 40, 0);
        send_beat(rnd_data(), 20, 0);
        #1 reset = 1'b0;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_in_ready", 256'(in_ready), 256'(1));
        check("midrst_len_err", 256'(len_err), 256'(0));
        check("midrst_out_data", out_data, '0);
        @(posedge clk);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        check("midrst_ready_after", 256'(in_ready), 256'(1));
        send_beat(rnd_data(), 12, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
